store_buffer: RTL and testbench

Store queue between the memory stage and `data_cache`. It accepts stores from the pipeline into a DEPTH-entry FIFO and drains them into the cache's single port whenever no load needs it. It also arbitrates that port between queued stores and incoming loads, and flags loads that hit a pending store's word so the pipeline can stall them until the store has drained.

---
 rtl/store_buffer.sv | 152 +++++++++++++++
 tb/tb_store_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//
// Store queue between the memory stage and data_cache. Aligned stores are queued in a
// DEPTH-entry FIFO and drained into the cache's single port on any cycle without an
// unhazarded load. Loads whose word matches a pending store are flagged so the pipeline
// stalls them until that store has drained.
//
// Ports:
//   i_Clock, i_Reset_n               clock, asynchronous active-low reset
//   i_StoreValid/Mode/Address/Data   store request (data right-aligned)
//   o_StoreReady                     FIFO not full (registered state only)
//   o_MisalignedStore                current store is misaligned and dropped
//   i_LoadValid/Mode/Address         load request
//   o_LoadHazard                     load word matches a pending store
//   o_CacheWriteEnable/ReadEnable    data_cache port controls
//   o_CacheMode/Address/Data         data_cache port operands
//   o_Empty                          no pending stores

module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_StoreValid,
    input  logic [2:0]  i_StoreMode,
    input  logic [31:0] i_StoreAddress,
    input  logic [31:0] i_StoreData,
    output logic        o_StoreReady,
    output logic        o_MisalignedStore,
    input  logic        i_LoadValid,
    input  logic [2:0]  i_LoadMode,
    input  logic [31:0] i_LoadAddress,
    output logic        o_LoadHazard,
    output logic        o_CacheWriteEnable,
    output logic        o_CacheReadEnable,
    output logic [2:0]  o_CacheMode,
    output logic [31:0] o_CacheAddress,
    output logic [31:0] o_CacheData,
    output logic        o_Empty
);

    // Store mode encodings shared with data_cache.
    localparam logic [2:0] STORE_BYTE = 3'b000;
    localparam logic [2:0] STORE_HALF = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(DEPTH);

    logic [2:0]  entryMode    [DEPTH];
    logic [31:0] entryAddress [DEPTH];
    logic [31:0] entryData    [DEPTH];

    logic [PtrWidth-1:0] wrPtrQ, wrPtrD;
    logic [PtrWidth-1:0] rdPtrQ, rdPtrD;
    logic [PtrWidth:0]   countQ, countD;

    logic isStoreMode;
    logic misaligned;
    logic enqueue;
    logic drain;
    logic notEmpty;
    logic wordHit;
    logic loadHazard;
    logic storeReady;

    // Store classification and acceptance
    always_comb begin
        isStoreMode = (i_StoreMode == STORE_BYTE) || (i_StoreMode == STORE_HALF) ||
                      (i_StoreMode == STORE_WORD);
        misaligned  = ((i_StoreMode == STORE_HALF) && i_StoreAddress[0]) ||
                      ((i_StoreMode == STORE_WORD) && (i_StoreAddress[1:0] != 2'b00));
        storeReady  = (countQ != FullCount);
        notEmpty    = (countQ != '0);
        enqueue     = i_StoreValid && storeReady && isStoreMode && !misaligned;
    end

    // Word-granular match against the occupied window [rdPtr, rdPtr + count).
    always_comb begin
        wordHit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((PtrWidth + 1)'(i) < countQ) &&
                (entryAddress[rdPtrQ + PtrWidth'(i)][31:2] == i_LoadAddress[31:2])) begin
                wordHit = 1'b1;
            end
        end
    end

    // A hazarded load still lets the head drain, so a stalled load cannot deadlock.
    always_comb begin
        loadHazard = i_LoadValid && wordHit;
        drain      = notEmpty && (!i_LoadValid || loadHazard);
    end

    // Pointer and occupancy next state
    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (enqueue) begin
            wrPtrD = wrPtrQ + PtrWidth'(1);
        end
        if (drain) begin
            rdPtrD = rdPtrQ + PtrWidth'(1);
        end
        case ({enqueue, drain})
            2'b10:   countD = countQ + (PtrWidth + 1)'(1);
            2'b01:   countD = countQ - (PtrWidth + 1)'(1);
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge i_Clock) begin
        if (enqueue) begin
            entryMode[wrPtrQ]    <= i_StoreMode;
            entryAddress[wrPtrQ] <= i_StoreAddress;
            entryData[wrPtrQ]    <= i_StoreData;
        end
    end

    // Cache port mux
    always_comb begin
        o_StoreReady       = storeReady;
        o_MisalignedStore  = i_StoreValid && misaligned;
        o_LoadHazard       = loadHazard;
        o_Empty            = !notEmpty;
        o_CacheWriteEnable = drain;
        o_CacheReadEnable  = i_LoadValid && !loadHazard;
        o_CacheMode        = i_LoadMode;
        o_CacheAddress     = i_LoadAddress;
        o_CacheData        = '0;
        if (drain) begin
            o_CacheMode    = entryMode[rdPtrQ];
            o_CacheAddress = entryAddress[rdPtrQ];
            o_CacheData    = entryData[rdPtrQ];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] LW = 3'b010;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sv;
    logic [2:0]  smode;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        lv;
    logic [2:0]  lmode;
    logic [31:0] la;
    logic        ready, mis, haz, we, re, empty;
    logic [2:0]  cmode;
    logic [31:0] caddr, cdata;

    int checks = 0;
    int errors = 0;

    entry_t q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .i_Clock           (clk),
        .i_Reset_n         (rstN),
        .i_StoreValid      (sv),
        .i_StoreMode       (smode),
        .i_StoreAddress    (sa),
        .i_StoreData       (sd),
        .o_StoreReady      (ready),
        .o_MisalignedStore (mis),
        .i_LoadValid       (lv),
        .i_LoadMode        (lmode),
        .i_LoadAddress     (la),
        .o_LoadHazard      (haz),
        .o_CacheWriteEnable(we),
        .o_CacheReadEnable (re),
        .o_CacheMode       (cmode),
        .o_CacheAddress    (caddr),
        .o_CacheData       (cdata),
        .o_Empty           (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sv = 1'b0; smode = 3'b111; sa = '0; sd = '0;
        lv = 1'b0; lmode = '0; la = '0;
    endtask

    task automatic putStore(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        sv = 1'b1; smode = m; sa = a; sd = d;
    endtask

    // Reference model: a queue of pending stores, outputs derived from its contents.
    initial begin
        logic expHaz, expMis, expDrain, expReady, isStore, enq;
        forever begin
            @(negedge clk);
            if (!rstN) q.delete();
            expHaz = 1'b0;
            if (lv) begin
                foreach (q[k]) if (q[k].addr[31:2] == la[31:2]) expHaz = 1'b1;
            end
            expMis   = sv && (((smode == SH) && sa[0]) || ((smode == SW) && (sa[1:0] != 0)));
            isStore  = (smode == SB) || (smode == SH) || (smode == SW);
            expReady = (q.size() < DEPTH);
            expDrain = (q.size() != 0) && (!lv || expHaz);
            chk("m_ready", ready, expReady);
            chk("m_misaligned", mis, expMis);
            chk("m_hazard", haz, expHaz);
            chk("m_empty", empty, q.size() == 0);
            chk("m_we", we, expDrain);
            chk("m_re", re, lv && !expHaz);
            chk("m_mode", cmode, expDrain ? q[0].mode : lmode);
            chk("m_addr", caddr, expDrain ? q[0].addr : la);
            chk("m_data", cdata, expDrain ? q[0].data : 32'h0);
            if (rstN) begin
                enq = sv && expReady && isStore && !expMis;
                if (expDrain) void'(q.pop_front());
                if (enq) q.push_back('{mode: smode, addr: sa, data: sd});
            end
        end
    end

    initial begin
        rstN = 1'b0;
        idle();
        // Reset state
        repeat (3) step();
        lv = 1'b1; la = 32'h40;
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_ready", ready, 1);
        chk("rst_we", we, 0);
        chk("rst_haz", haz, 0);
        chk("rst_mis", mis, 0);
        chk("rst_re_follows_load", re, 1);
        step();
        idle();
        rstN = 1'b1;
        step();

        // Single store word
        putStore(SW, 32'h100, 32'hCAFEF00D);
        #2 chk("sw_ready", ready, 1);
        chk("sw_we_before", we, 0);
        step();
        idle();
        #2 chk("sw_we", we, 1);
        chk("sw_addr", caddr, 32'h100);
        chk("sw_data", cdata, 32'hCAFEF00D);
        chk("sw_mode", cmode, SW);
        step();
        #2 chk("sw_empty_after", empty, 1);
        chk("sw_we_after", we, 0);

        // Fill and backpressure behind an unhazarded load
        lv = 1'b1; lmode = LW; la = 32'h800;
        for (int i = 0; i < 4; i++) begin
            putStore(SW, 32'(4 * i), 32'h1000 + 32'(i));
            #2 chk("fill_ready", ready, 1);
            chk("fill_we", we, 0);
            step();
        end
        putStore(SW, 32'h10, 32'h1004);
        #2 chk("full_ready", ready, 0);
        chk("full_we", we, 0);
        chk("full_re", re, 1);
        chk("full_addr_is_load", caddr, 32'h800);
        step();
        #2 chk("full_hold_we", we, 0);
        step();
        lv = 1'b0;
        #2 chk("drain0_ready", ready, 0);
        chk("drain0_addr", caddr, 32'h0);
        chk("drain0_data", cdata, 32'h1000);
        step();
        #2 chk("fifth_ready", ready, 1);
        chk("drain1_addr", caddr, 32'h4);
        step();
        sv = 1'b0;
        for (int j = 2; j < 5; j++) begin
            #2 chk("drain_we", we, 1);
            chk("drain_addr", caddr, 32'(4 * j));
            chk("drain_data", cdata, 32'h1000 + 32'(j));
            step();
        end
        #2 chk("fill_empty", empty, 1);
        step();

        // Hazard: byte store at 0x203 against word load at 0x200
        lv = 1'b1; lmode = LW; la = 32'h800;
        putStore(SB, 32'h203, 32'hAB);
        step();
        sv = 1'b0; la = 32'h200;
        #2 chk("haz_flag", haz, 1);
        chk("haz_re", re, 0);
        chk("haz_we", we, 1);
        chk("haz_addr", caddr, 32'h203);
        chk("haz_data", cdata, 32'hAB);
        chk("haz_mode", cmode, SB);
        step();
        #2 chk("haz_clear", haz, 0);
        chk("haz_re_after", re, 1);
        chk("haz_load_addr", caddr, 32'h200);
        chk("haz_we_after", we, 0);
        step();
        idle();

        // Misaligned and non-store modes are dropped
        putStore(SH, 32'h101, 32'h55);
        #2 chk("mis_half", mis, 1);
        step();
        putStore(SW, 32'h102, 32'h66);
        #2 chk("mis_word", mis, 1);
        chk("mis_empty", empty, 1);
        step();
        putStore(3'b111, 32'h104, 32'h77);
        #2 chk("nonstore_mis", mis, 0);
        step();
        idle();
        #2 chk("mis_still_empty", empty, 1);
        chk("mis_no_write", we, 0);
        step();

        // Wrap-around: back-to-back stores drain in issue order
        for (int i = 0; i < 10; i++) begin
            putStore(SW, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
            #2 if (i > 0) chk("wrap_addr", caddr, 32'h40 + 32'(4 * (i - 1)));
            step();
        end
        idle();
        #2 chk("wrap_last", caddr, 32'h64);
        step();

        // Reset with three entries pending
        lv = 1'b1; lmode = LW; la = 32'h900;
        for (int i = 0; i < 3; i++) begin
            putStore(SW, 32'h50 + 32'(4 * i), 32'(i));
            step();
        end
        sv = 1'b0;
        #2 chk("pend_empty", empty, 0);
        rstN = 1'b0;
        #1 chk("rst_mid_empty", empty, 1);
        chk("rst_mid_we", we, 0);
        step();
        lv = 1'b0;
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("post_rst_we", we, 0);
            step();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle();
            r = $urandom_range(0, 9);
            if (r < 4) begin
                putStore(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                     : 3'($urandom_range(0, 2)),
                         32'h1000 + 32'($urandom_range(0, 63)), $urandom);
            end else if (r < 8) begin
                lv = 1'b1;
                lmode = 3'($urandom_range(0, 7));
                la = 32'h1000 + 32'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 249) == 0) rstN = 1'b0;
            else rstN = 1'b1;
            step();
        end
        idle();
        rstN = 1'b1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
